// File: rtl/hazard_control_unit.sv
// Decode-stage hazard control: detects load-use and branch-compare hazards, drives stall/flush
// controls, and keeps saturating stall and flush counters for performance debug.
module hazard_control_unit #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] if_id_rs,
    input  logic [REG_ADDR_W-1:0] if_id_rt,
    input  logic                  id_uses_rt,
    input  logic                  id_branch,
    input  logic                  id_jump,
    input  logic                  branch_taken,
    input  logic                  id_ex_mem_read,
    input  logic                  id_ex_reg_write,
    input  logic [REG_ADDR_W-1:0] id_ex_dest,
    input  logic                  ex_mem_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_mem_dest,
    output logic                  pc_write_en,
    output logic                  if_id_write_en,
    output logic                  data_hazard,
    output logic                  if_flush,
    output logic [1:0]            hz_state,
    output logic [CNT_WIDTH-1:0]  stall_cycles,
    output logic [CNT_WIDTH-1:0]  flush_count
);

    typedef enum logic [1:0] {
        StRun    = 2'b00,
        StStall1 = 2'b01,
        StStall2 = 2'b10
    } hz_state_e;

    hz_state_e            state_q, state_d;
    logic [CNT_WIDTH-1:0] stall_q, stall_d;
    logic [CNT_WIDTH-1:0] flush_q, flush_d;

    logic ex_match, mem_match;
    logic need2, need1, need_any;
    logic stall, flush;

    function automatic logic reg_match(input logic [REG_ADDR_W-1:0] d,
                                       input logic [REG_ADDR_W-1:0] rs,
                                       input logic [REG_ADDR_W-1:0] rt,
                                       input logic                  uses_rt);
        return (d != '0) && ((d == rs) || (uses_rt && (d == rt)));
    endfunction

    always_comb begin
        ex_match  = reg_match(id_ex_dest, if_id_rs, if_id_rt, id_uses_rt);
        mem_match = reg_match(ex_mem_dest, if_id_rs, if_id_rt, id_uses_rt);
        need2     = id_branch && id_ex_mem_read && ex_match;
        need1     = !need2 && ((id_ex_mem_read && ex_match) ||
                               (id_branch && id_ex_reg_write && ex_match) ||
                               (id_branch && ex_mem_mem_read && mem_match));
        need_any  = need2 || need1;
    end

    // Outputs are forced to their idle values while reset is held, regardless of hazard inputs.
    always_comb begin
        stall = 1'b0;
        flush = 1'b0;
        if (!reset) begin
            if (state_q == StRun) begin
                stall = need_any;
                flush = !need_any && ((id_branch && branch_taken) || id_jump);
            end else begin
                stall = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = StRun;
        if (state_q == StRun && need2) begin
            state_d = StStall1;
        end
        stall_d = stall_q;
        if (stall && (stall_q != '1)) begin
            stall_d = stall_q + CNT_WIDTH'(1);
        end
        flush_d = flush_q;
        if (flush && (flush_q != '1)) begin
            flush_d = flush_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StRun;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign pc_write_en    = !stall;
    assign if_id_write_en = !stall;
    assign data_hazard    = stall;
    assign if_flush       = flush;
    assign hz_state       = state_q;
    assign stall_cycles   = stall_q;
    assign flush_count    = flush_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit; a second instance with 2-bit counters checks saturation.
module tb_hazard_control_unit;

    logic       clk;
    logic       reset;
    logic [4:0] if_id_rs, if_id_rt, id_ex_dest, ex_mem_dest;
    logic       id_uses_rt, id_branch, id_jump, branch_taken;
    logic       id_ex_mem_read, id_ex_reg_write, ex_mem_mem_read;

    logic        pc_write_en, if_id_write_en, data_hazard, if_flush;
    logic [1:0]  hz_state;
    logic [15:0] stall_cycles, flush_count;

    logic       s_pc_we, s_ifid_we, s_dh, s_fl;
    logic [1:0] s_state;
    logic [1:0] s_stall_cycles, s_flush_count;

    int n_vec = 0;
    int n_err = 0;

    hazard_control_unit #(.REG_ADDR_W(5), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .id_uses_rt(id_uses_rt),
        .id_branch(id_branch), .id_jump(id_jump), .branch_taken(branch_taken),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_reg_write(id_ex_reg_write),
        .id_ex_dest(id_ex_dest), .ex_mem_mem_read(ex_mem_mem_read), .ex_mem_dest(ex_mem_dest),
        .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en),
        .data_hazard(data_hazard), .if_flush(if_flush), .hz_state(hz_state),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    hazard_control_unit #(.REG_ADDR_W(5), .CNT_WIDTH(2)) dut_small (
        .clk(clk), .reset(reset),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .id_uses_rt(id_uses_rt),
        .id_branch(id_branch), .id_jump(id_jump), .branch_taken(branch_taken),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_reg_write(id_ex_reg_write),
        .id_ex_dest(id_ex_dest), .ex_mem_mem_read(ex_mem_mem_read), .ex_mem_dest(ex_mem_dest),
        .pc_write_en(s_pc_we), .if_id_write_en(s_ifid_we),
        .data_hazard(s_dh), .if_flush(s_fl), .hz_state(s_state),
        .stall_cycles(s_stall_cycles), .flush_count(s_flush_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        if_id_rs = '0; if_id_rt = '0; id_ex_dest = '0; ex_mem_dest = '0;
        id_uses_rt = 0; id_branch = 0; id_jump = 0; branch_taken = 0;
        id_ex_mem_read = 0; id_ex_reg_write = 0; ex_mem_mem_read = 0;
    endtask

    // Check combinational outputs mid-cycle, then advance to just after the next rising edge.
    task automatic cyc(input string tag, input logic e_stall, input logic e_flush,
                       input logic [1:0] e_state);
        @(negedge clk);
        chk({tag, ".pc_we"}, 32'(pc_write_en), 32'(!e_stall));
        chk({tag, ".ifid_we"}, 32'(if_id_write_en), 32'(!e_stall));
        chk({tag, ".hazard"}, 32'(data_hazard), 32'(e_stall));
        chk({tag, ".flush"}, 32'(if_flush), 32'(e_flush));
        chk({tag, ".state"}, 32'(hz_state), 32'(e_state));
        @(posedge clk);
        #1;
    endtask

    // STALL2 is a reserved encoding and must never appear.
    always @(negedge clk) begin
        if (hz_state == 2'b10) chk("stall2_reached", 32'(hz_state), 32'd0);
    end

    initial begin
        reset = 1'b1;
        clear_inputs();
        #1;
        chk("rst.pc_we", 32'(pc_write_en), 32'd1);
        chk("rst.hazard", 32'(data_hazard), 32'd0);
        chk("rst.flush", 32'(if_flush), 32'd0);
        chk("rst.state", 32'(hz_state), 32'd0);
        chk("rst.stall_cnt", 32'(stall_cycles), 32'd0);
        chk("rst.flush_cnt", 32'(flush_count), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // T1 load-use on rs
        id_ex_mem_read = 1; id_ex_dest = 5; if_id_rs = 5;
        cyc("t1.stall", 1, 0, 2'b00);
        chk("t1.stall_cnt", 32'(stall_cycles), 32'd1);
        id_ex_mem_read = 0; id_ex_dest = 0;
        cyc("t1.resume", 0, 0, 2'b00);
        chk("t1.stall_cnt_hold", 32'(stall_cycles), 32'd1);

        // T2 beq after lw: two stalls, taken flush suppressed during the stall
        clear_inputs();
        id_branch = 1; id_uses_rt = 1; if_id_rs = 2; if_id_rt = 3;
        id_ex_mem_read = 1; id_ex_dest = 3;
        cyc("t2.stall_a", 1, 0, 2'b00);
        id_ex_mem_read = 0; id_ex_dest = 0; ex_mem_mem_read = 1; ex_mem_dest = 3;
        branch_taken = 1;
        cyc("t2.stall_b", 1, 0, 2'b01);
        chk("t2.stall_cnt", 32'(stall_cycles), 32'd3);
        ex_mem_mem_read = 0; ex_mem_dest = 0;
        cyc("t2.flush", 0, 1, 2'b00);
        chk("t2.flush_cnt", 32'(flush_count), 32'd1);
        clear_inputs();
        cyc("t2.idle", 0, 0, 2'b00);
        chk("t2.flush_cnt_hold", 32'(flush_count), 32'd1);

        // T3 beq after add: one stall then flush; jump flushes immediately
        id_branch = 1; branch_taken = 1; if_id_rs = 7;
        id_ex_reg_write = 1; id_ex_dest = 7;
        cyc("t3.stall", 1, 0, 2'b00);
        id_ex_reg_write = 0; id_ex_dest = 0;
        cyc("t3.flush", 0, 1, 2'b00);
        chk("t3.cnts", 32'({stall_cycles, flush_count}), {16'd4, 16'd2});
        clear_inputs();
        id_jump = 1;
        cyc("t3.jump", 0, 1, 2'b00);
        chk("t3.flush_cnt", 32'(flush_count), 32'd3);
        // Branch against a load in MEM needs one stall; not-taken branch never flushes
        clear_inputs();
        id_branch = 1; if_id_rs = 4; ex_mem_mem_read = 1; ex_mem_dest = 4;
        cyc("t3.mem_ld", 1, 0, 2'b00);
        ex_mem_mem_read = 0;
        cyc("t3.not_taken", 0, 0, 2'b00);
        // Load-use through rt
        clear_inputs();
        id_uses_rt = 1; if_id_rt = 12; id_ex_mem_read = 1; id_ex_dest = 12;
        cyc("t3.rt_use", 1, 0, 2'b00);
        chk("t3.stall_cnt", 32'(stall_cycles), 32'd6);

        // T4 no-hazard cases
        clear_inputs();
        id_ex_mem_read = 1; id_ex_dest = 0; if_id_rs = 0;
        cyc("t4.zero", 0, 0, 2'b00);
        id_ex_dest = 9; if_id_rt = 9; if_id_rs = 1; id_uses_rt = 0;
        cyc("t4.no_rt", 0, 0, 2'b00);
        clear_inputs();
        id_ex_reg_write = 1; id_ex_dest = 8; if_id_rs = 8;
        cyc("t4.alu_fwd", 0, 0, 2'b00);
        chk("t4.stall_cnt", 32'(stall_cycles), 32'd6);

        // T5 async reset in the middle of STALL1
        clear_inputs();
        id_branch = 1; if_id_rs = 6; id_ex_mem_read = 1; id_ex_dest = 6;
        cyc("t5.enter", 1, 0, 2'b00);
        #2;
        reset = 1'b1;
        #1;
        chk("t5.state", 32'(hz_state), 32'd0);
        chk("t5.hazard", 32'(data_hazard), 32'd0);
        chk("t5.pc_we", 32'(pc_write_en), 32'd1);
        chk("t5.cnts", 32'({stall_cycles, flush_count}), 32'd0);
        clear_inputs();
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc("t5.after", 0, 0, 2'b00);
        chk("t5.stall_cnt", 32'(stall_cycles), 32'd0);

        // T6 five back-to-back load-use stalls: 2-bit counter saturates at 3
        id_ex_mem_read = 1; id_ex_dest = 10; if_id_rs = 10;
        for (int k = 1; k <= 5; k++) begin
            cyc("t6.stall", 1, 0, 2'b00);
            chk("t6.big_cnt", 32'(stall_cycles), 32'(k));
            chk("t6.small_cnt", 32'(s_stall_cycles), (k > 3) ? 32'd3 : 32'(k));
        end
        clear_inputs();
        cyc("t6.idle", 0, 0, 2'b00);
        chk("t6.small_hold", 32'(s_stall_cycles), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
